// File: rtl/mul_share_pkg.sv
// Shared constants, arbiter pick type and round-robin scan for the shared multiplier.
package mul_share_pkg;

   localparam int unsigned W     = 4;
   localparam int unsigned N_REQ = 4;
   localparam int unsigned IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int unsigned CNT_W = 16;

   typedef struct packed {
      logic           found;
      logic [IDW-1:0] idx;
   } pick_t;

   // First set bit of valid, scanning upward from ptr and wrapping modulo N_REQ.
   function automatic pick_t rr_pick(input logic [N_REQ-1:0] valid, input logic [IDW-1:0] ptr);
      pick_t       p;
      int unsigned j;
      p.found = 1'b0;
      p.idx   = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         j = (32'(ptr) + k) % N_REQ;
         if (!p.found && valid[IDW'(j)]) begin
            p.found = 1'b1;
            p.idx   = IDW'(j);
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/mul_share_arbiter_mul_core_w.sv
// Purely combinational unsigned W x W -> 2W multiplier; any equivalent netlist may replace it.
module mul_core_w
   import mul_share_pkg::*;
(
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic [2*W-1:0] z_c
);

   // Full-width product, operands widened first so nothing is truncated.
   always_comb begin
      z_c = (2*W)'(a) * (2*W)'(b);
   end

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin sharing of one multiplier among N_REQ requesters with a one-deep result register.
module mul_share_arbiter
   import mul_share_pkg::*;
#(
   parameter int unsigned OP_CNT_W = CNT_W
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_REQ-1:0]      in_valid,
   output logic [N_REQ-1:0]      in_ready,
   input  logic [N_REQ*W-1:0]    in_a,
   input  logic [N_REQ*W-1:0]    in_b,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [2*W-1:0]        out_z,
   output logic [IDW-1:0]        out_id,
   output logic [OP_CNT_W-1:0]   op_count
);

   logic                out_valid_q, out_valid_d;
   logic [2*W-1:0]      out_z_q, out_z_d;
   logic [IDW-1:0]      out_id_q, out_id_d;
   logic [IDW-1:0]      rr_ptr_q, rr_ptr_d;
   logic [OP_CNT_W-1:0] op_count_q, op_count_d;

   pick_t          pick;
   logic           slot_free;
   logic           accept;
   logic [W-1:0]   a_sel;
   logic [W-1:0]   b_sel;
   logic [2*W-1:0] prod_c;

   // Grant selection and accept; in_ready is held low during reset.
   always_comb begin
      pick      = rr_pick(in_valid, rr_ptr_q);
      slot_free = !out_valid_q || out_ready;
      accept    = pick.found && slot_free && !rst;
      in_ready  = '0;
      if (accept) begin
         in_ready[pick.idx] = 1'b1;
      end
   end

   // Operand mux feeding the shared multiplier from the granted requester.
   always_comb begin
      a_sel = '0;
      b_sel = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (IDW'(i) == pick.idx) begin
            a_sel = in_a[i*W +: W];
            b_sel = in_b[i*W +: W];
         end
      end
   end

   mul_core_w u_mul (
      .a   (a_sel),
      .b   (b_sel),
      .z_c (prod_c)
   );

   // Next-state for result register, round-robin pointer and saturating counter.
   always_comb begin
      out_valid_d = out_valid_q;
      out_z_d     = out_z_q;
      out_id_d    = out_id_q;
      rr_ptr_d    = rr_ptr_q;
      op_count_d  = op_count_q;
      if (accept) begin
         out_valid_d = 1'b1;
         out_z_d     = prod_c;
         out_id_d    = pick.idx;
         rr_ptr_d    = (pick.idx == IDW'(N_REQ - 1)) ? '0 : pick.idx + IDW'(1);
         op_count_d  = (&op_count_q) ? op_count_q : op_count_q + OP_CNT_W'(1);
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // State registers, asynchronously cleared.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_z_q     <= '0;
         out_id_q    <= '0;
         rr_ptr_q    <= '0;
         op_count_q  <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_z_q     <= out_z_d;
         out_id_q    <= out_id_d;
         rr_ptr_q    <= rr_ptr_d;
         op_count_q  <= op_count_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_z     = out_z_q;
   assign out_id    = out_id_q;
   assign op_count  = op_count_q;

endmodule
